pfiform_join_arb: RTL

PFIFORM_JOIN_ARB -- requirements
Module: pfiform_join_arb

---
 rtl/pfiform_join_arb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pfiform_join_arb.sv
// pfiform_join_arb
//   Two-requester burst arbiter feeding the PFIFORM join port. The arbiter
//   grants one requester at a time and holds that grant for the whole burst.
//   Accepted beats are registered onto JoinEnable/JoinAmout/JoinData one
//   cycle after acceptance. When a burst ends and the other requester is
//   already waiting, ownership passes straight across without an idle cycle.
//
//   Optional feature macro: PFIFORM_ARB_BEATCAP_EN
//     When defined, an owner that has sent MAX_BEATS beats hands over to a
//     waiting requester even if its burst has not ended.
//
// Ports
//   i_core_clk                 clock (rising edge)
//   i_rx_rst                   asynchronous reset, active high
//   i_reqN_valid/last/amount/data   requester N beat (N = 0,1)
//   o_reqN_ready               beat from requester N accepted this cycle
//   JoinPermit                 PFIFORM will accept a beat driven next cycle
//   JoinEnable/JoinAmout/JoinData   registered beat to PFIFORM
//   o_grant                    one-hot current owner, 0 when idle
module pfiform_join_arb #(
  parameter int DATA_W    = 96,
  parameter int AMT_W     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic              i_core_clk,
  input  logic              i_rx_rst,
  input  logic              i_req0_valid,
  input  logic              i_req0_last,
  input  logic [AMT_W-1:0]  i_req0_amount,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic              i_req1_last,
  input  logic [AMT_W-1:0]  i_req1_amount,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  input  logic              JoinPermit,
  output logic              JoinEnable,
  output logic [AMT_W-1:0]  JoinAmout,
  output logic [DATA_W-1:0] JoinData,
  output logic [1:0]        o_grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t r_state, w_state_nxt;
  logic   r_rr, w_rr_nxt;

  logic   w_acc0, w_acc1, w_acc, w_acc_last, w_other_vld;
  state_t w_own_other;

  // Readiness depends only on ownership and the downstream permit, so a
  // non-owner never sees ready and IDLE never accepts.
  assign o_req0_ready = (r_state == OWN0) & JoinPermit;
  assign o_req1_ready = (r_state == OWN1) & JoinPermit;

  assign w_acc0     = i_req0_valid & o_req0_ready;
  assign w_acc1     = i_req1_valid & o_req1_ready;
  assign w_acc      = w_acc0 | w_acc1;
  assign w_acc_last = (w_acc0 & i_req0_last) | (w_acc1 & i_req1_last);

  // Waiting status of the requester that does not currently own the port.
  assign w_other_vld = (r_state == OWN0) ? i_req1_valid : i_req0_valid;
  assign w_own_other = (r_state == OWN0) ? OWN1 : OWN0;

  assign o_grant = {r_state == OWN1, r_state == OWN0};

`ifdef PFIFORM_ARB_BEATCAP_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_cap_hit;

  // This accept is the MAX_BEATS-th beat of the current ownership.
  assign w_cap_hit = w_acc & (r_cnt == CNT_W'(MAX_BEATS - 1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    case (r_state)
      IDLE: begin
        if (i_req0_valid && i_req1_valid) w_state_nxt = r_rr ? OWN1 : OWN0;
        else if (i_req0_valid)            w_state_nxt = OWN0;
        else if (i_req1_valid)            w_state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (w_acc_last) begin
          // Preference moves to the other side; hand over directly if it waits.
          w_rr_nxt    = (r_state == OWN0);
          w_state_nxt = w_other_vld ? w_own_other : IDLE;
        end
`ifdef PFIFORM_ARB_BEATCAP_EN
        else if (w_cap_hit && w_other_vld) begin
          w_rr_nxt    = (r_state == OWN0);
          w_state_nxt = w_own_other;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef PFIFORM_ARB_BEATCAP_EN
  // Counter restarts on any ownership change and also when the cap is hit
  // with nobody waiting, so the owner gets a fresh quota.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    else if (w_acc)             w_cnt_nxt = w_cap_hit ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end
`endif

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  // Output beat register: strobe pulses per accept, payload holds otherwise.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      JoinEnable <= 1'b0;
      JoinAmout  <= '0;
      JoinData   <= '0;
    end else begin
      JoinEnable <= w_acc;
      if (w_acc0) begin
        JoinAmout <= i_req0_amount;
        JoinData  <= i_req0_data;
      end else if (w_acc1) begin
        JoinAmout <= i_req1_amount;
        JoinData  <= i_req1_data;
      end
    end
  end

endmodule
